// File: rtl/ifetch_pair_buffer.sv
// ifetch_pair_buffer
//   Instruction-fetch stage in front of the dual-issue decoder. It issues one
//   64-bit pair read per request, queues returned pairs in a small FIFO with
//   their PC and slot-0 enable, and restarts fetch on control-flow redirects.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   i_addr, i_en      : instruction memory byte address / read request
//   i_rdata           : read data, valid one cycle after i_en
//   redirect_vld/_pc  : redirect request and word-PC target (may be odd)
//   out_vld, out_rdy  : head-of-queue handshake towards decode
//   out_pc            : even PC of the presented pair
//   out_instr0/1      : even word / odd word of the pair
//   out_en0/1         : per-slot executable flags
//
// Build option
//   IFETCH_BYPASS_EN  : when defined, a response arriving into an empty FIFO
//                       is presented in the same cycle (1-cycle latency).
module ifetch_pair_buffer #(
  parameter int PC_W  = 14,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W+1:0] i_addr,
  output logic            i_en,
  input  logic [63:0]     i_rdata,
  input  logic            redirect_vld,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr0,
  output logic [31:0]     out_instr1,
  output logic            out_en0,
  output logic            out_en1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q;
  logic [PC_W-1:0] tag_pc_q;
  logic            tag_en0_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PC_W-1:0] mem_pc_q  [DEPTH];
  logic [31:0]     mem_i0_q  [DEPTH];
  logic [31:0]     mem_i1_q  [DEPTH];
  logic            mem_en0_q [DEPTH];

  logic issue, rsp_vld, fifo_empty, byp, push, pop;
  logic [CW-1:0] credit_used;

  // Credits: stored entries plus the read in flight must fit in the FIFO, so
  // a returning response always finds a free slot. Pops this cycle are not
  // credited back until the count register updates.
  assign credit_used = count_q + CW'(inflight_q);
  assign issue       = ~rst & ~redirect_vld & (credit_used < CW'(DEPTH));
  assign i_en        = issue;
  assign i_addr      = {fetch_pc_q[PC_W-1:1], 3'b000};

  // A redirect in the response cycle kills the returning pair.
  assign rsp_vld    = inflight_q & ~redirect_vld & ~rst;
  assign fifo_empty = (count_q == '0);

`ifdef IFETCH_BYPASS_EN
  assign byp = rsp_vld & fifo_empty;
`else
  assign byp = 1'b0;
`endif

  assign out_vld = ~fifo_empty | byp;
  assign pop     = ~fifo_empty & out_rdy;
  // A bypassed pair taken by decode in the same cycle is never written.
  assign push    = rsp_vld & ~(byp & out_rdy);

  always_comb begin
    out_pc     = '0;
    out_instr0 = '0;
    out_instr1 = '0;
    out_en0    = 1'b0;
    out_en1    = 1'b0;
    if (byp) begin
      out_pc     = tag_pc_q;
      out_instr0 = i_rdata[63:32];
      out_instr1 = i_rdata[31:0];
      out_en0    = tag_en0_q;
      out_en1    = 1'b1;
    end else if (!fifo_empty) begin
      out_pc     = mem_pc_q[rd_ptr_q];
      out_instr0 = mem_i0_q[rd_ptr_q];
      out_instr1 = mem_i1_q[rd_ptr_q];
      out_en0    = mem_en0_q[rd_ptr_q];
      out_en1    = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_vld) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      // Next pair: advance the even PC, wrapping at the top of the space.
      if (issue) fetch_pc_d = {fetch_pc_q[PC_W-1:1] + (PC_W-1)'(1), 1'b0};
      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Tag and storage registers carry data only; their contents are ignored
  // whenever the control state marks them invalid.
  always_ff @(posedge clk) begin
    if (issue) begin
      tag_pc_q  <= {fetch_pc_q[PC_W-1:1], 1'b0};
      tag_en0_q <= ~fetch_pc_q[0];
    end
    if (push) begin
      mem_pc_q[wr_ptr_q]  <= tag_pc_q;
      mem_i0_q[wr_ptr_q]  <= i_rdata[63:32];
      mem_i1_q[wr_ptr_q]  <= i_rdata[31:0];
      mem_en0_q[wr_ptr_q] <= tag_en0_q;
    end
  end

endmodule

// File: tb/tb_ifetch_pair_buffer.sv
module tb_ifetch_pair_buffer;

  localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr;
  logic        i_en;
  logic [63:0] i_rdata;
  logic        redirect_vld;
  logic [13:0] redirect_pc;
  logic        out_vld;
  logic        out_rdy;
  logic [13:0] out_pc;
  logic [31:0] out_instr0, out_instr1;
  logic        out_en0, out_en1;

  ifetch_pair_buffer #(.PC_W(14), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_en(i_en), .i_rdata(i_rdata),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pc(out_pc),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_en0(out_en0), .out_en1(out_en1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        en0;
  } ent_t;

  // Reference model: expected stream of pairs, fetch PC and one outstanding read.
  ent_t        q[$];
  logic [13:0] m_pc = '0;
  logic        m_inflight = 1'b0;
  logic [13:0] m_tag_pc = '0;
  logic        m_tag_en0 = 1'b0;
  logic        issue_snap = 1'b0;
  logic        bypass_taken = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [63:0] mem(input logic [13:0] pc);
    logic [15:0] a;
    a = {2'b00, pc};
    return {a * 16'd3 + 16'h1111, a, ~a, a ^ 16'hA5A5};
  endfunction

  function automatic ent_t mk(input logic [13:0] pc, input logic en0);
    ent_t e;
    logic [63:0] d;
    d = mem(pc);
    e.pc = pc; e.i0 = d[63:32]; e.i1 = d[31:0]; e.en0 = en0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares request port and head-of-queue against the model.
  initial forever begin
    int   occ;
    logic exp_issue, have, from_rsp;
    ent_t e;
    @(negedge clk); #1;
    occ = q.size();
    exp_issue = !rst && !redirect_vld && (occ + int'(m_inflight) < DEPTH);
    chk("i_en", i_en, exp_issue);
    if (exp_issue) chk("i_addr", i_addr, {m_pc[13:1], 3'b000});
    chk("occupancy_le_depth", dut.count_q <= DEPTH, 1);
    issue_snap = exp_issue;
    if (!rst) begin
      have = 1'b0; from_rsp = 1'b0; e = '0;
      if (occ > 0) begin
        e = q[0]; have = 1'b1;
      end else if (BYP && m_inflight && !redirect_vld) begin
        e = mk(m_tag_pc, m_tag_en0); have = 1'b1; from_rsp = 1'b1;
      end
      chk("out_vld", out_vld, have);
      if (have && out_vld) begin
        chk("out_pc", out_pc, e.pc);
        chk("out_instr0", out_instr0, e.i0);
        chk("out_instr1", out_instr1, e.i1);
        chk("out_en0", out_en0, e.en0);
        chk("out_en1", out_en1, 1'b1);
      end
      if (have && out_rdy) begin
        if (from_rsp) bypass_taken = 1'b1;
        else void'(q.pop_front());
      end
    end
  end

  // Model update at the clock edge: flush, capture response, issue.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete(); m_pc = '0; m_inflight = 1'b0;
    end else if (redirect_vld) begin
      q.delete(); m_inflight = 1'b0; m_pc = redirect_pc;
    end else begin
      if (m_inflight && !bypass_taken) q.push_back(mk(m_tag_pc, m_tag_en0));
      if (issue_snap) begin
        m_tag_pc  = {m_pc[13:1], 1'b0};
        m_tag_en0 = ~m_pc[0];
        m_pc      = {m_pc[13:1] + 13'd1, 1'b0};
      end
      m_inflight = issue_snap;
    end
    bypass_taken = 1'b0;
  end

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [13:0] rpc);
    @(negedge clk);
    rst = r; out_rdy = rdy; redirect_vld = rv; redirect_pc = rpc;
    i_rdata = m_inflight ? mem(m_tag_pc) : {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; out_rdy = 1'b0; redirect_vld = 1'b0; redirect_pc = '0; i_rdata = '0;
    repeat (3) cyc(1, 0, 0, 0);
    // Streaming with decode always ready
    repeat (10) cyc(0, 1, 0, 0);
    // Stall until full, then drain
    repeat (3) cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0);
    // Redirect to odd PC with three entries queued and one read in flight
    repeat (2) cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 14'h0105);
    repeat (8) cyc(0, 1, 0, 0);
    // Redirect near the top of the PC space
    cyc(0, 1, 1, 14'h3FFE);
    repeat (6) cyc(0, 1, 0, 0);
    // Back-to-back redirects
    cyc(0, 1, 1, 14'h0010);
    cyc(0, 1, 1, 14'h0020);
    repeat (6) cyc(0, 1, 0, 0);
    // Reset while full
    repeat (8) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [13:0] t;
      case ($urandom_range(0, 3))
        0: t = 14'h3FFE;
        1: t = 14'h3FFF;
        default: t = 14'($urandom);
      endcase
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 11) == 0), t);
    end
    repeat (6) cyc(0, 1, 0, 0);
    @(negedge clk); #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
